// File: rtl/sram_like_responder_pkg.sv
// Shared types for the SRAM-like responder: size encodings, pending-entry layout, stamp width
// and the byte-strobe helper used by the write path.
package sram_like_responder_pkg;

    localparam int unsigned STAMP_W = 8;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic               is_read;
        logic [31:0]        rword;
        logic [STAMP_W-1:0] ready_stamp;
    } pend_entry_t;

    // Misaligned half/word accesses yield an all-zero strobe so the write is dropped.
    function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] lsb);
        logic [3:0] strb;
        strb = '0;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << lsb;
            SIZE_HALF: strb = lsb[0] ? 4'b0000 : (lsb[1] ? 4'b1100 : 4'b0011);
            default:   strb = (lsb == 2'b00) ? 4'b1111 : 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/sram_like_responder_if.sv
// SRAM-like split request/response bus: the CPU side is the master, the responder the slave.
interface sram_like_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_pend_fifo.sv
// Synchronous FIFO holding accepted-but-uncompleted transactions; head is read combinationally.
module sram_like_pend_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/sram_like_responder.sv
// Memory-side responder for the SRAM-like bus: accepts on addr_ok, completes in order on data_ok
// after DATA_LATENCY cycles. Define SRAM_LIKE_RAND_STALL_EN for LFSR-driven random backpressure.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    sram_like_responder_if.slave bus
);
    localparam int unsigned ENTRY_W = $bits(pend_entry_t);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]        ram_q [2**ADDR_W];
    logic [ADDR_W-1:0]  widx;
    logic [3:0]         strb;
    logic [31:0]        ram_word;

    logic               addr_ok, push, pop, stall, hold;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count_unused;
    logic [ENTRY_W-1:0] head_bits;
    pend_entry_t        push_entry, head_entry;

    logic [STAMP_W-1:0] stamp_q, stamp_d, elapsed;
    logic               data_ok_q, data_ok_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               unused_addr_hi;

    assign widx           = bus.addr[ADDR_W+1:2];
    assign strb           = byte_strobe(bus.size, bus.addr[1:0]);
    assign ram_word       = ram_q[widx];
    assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

`ifdef SRAM_LIKE_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign stall  = (lfsr_q[1:0] == 2'b00);
    assign hold   = (lfsr_q[3:2] == 2'b00);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_q <= 16'hACE1;
        else         lfsr_q <= lfsr_d;
    end
`else
    assign stall = 1'b0;
    assign hold  = 1'b0;
`endif

    // Full blocks acceptance even when the head pops this cycle: no pass-through.
    assign addr_ok     = resetn && bus.req && !fifo_full && !stall;
    assign bus.addr_ok = addr_ok;
    assign bus.data_ok = data_ok_q;
    assign bus.rdata   = rdata_q;

    assign push_entry.is_read     = !bus.wr;
    assign push_entry.rword       = ram_word;
    assign push_entry.ready_stamp = stamp_q + STAMP_W'(DATA_LATENCY);
    assign head_entry             = pend_entry_t'(head_bits);

    // Decide at the edge that opens the completion cycle, so compare against the next stamp.
    assign stamp_d = stamp_q + 1'b1;
    assign elapsed = stamp_d - head_entry.ready_stamp;

    always_comb begin
        push      = addr_ok;
        pop       = 1'b0;
        data_ok_d = 1'b0;
        rdata_d   = rdata_q;
        if (!hold) begin
            if (!fifo_empty && !elapsed[STAMP_W-1]) begin
                pop       = 1'b1;
                data_ok_d = 1'b1;
                if (head_entry.is_read) rdata_d = head_entry.rword;
            end else if (DATA_LATENCY == 1 && fifo_empty && addr_ok) begin
                // Latency 1 with nothing queued completes straight from the accept.
                push      = 1'b0;
                data_ok_d = 1'b1;
                if (!bus.wr) rdata_d = ram_word;
            end
        end
    end

    sram_like_pend_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pend_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_bits),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count_unused)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stamp_q   <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            stamp_q   <= stamp_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (addr_ok && bus.wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (strb[i]) ram_q[widx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

endmodule
